// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard unit: registers the fetched instruction, tracks downstream
// destination registers, and produces forwarding selects and a load-use stall.
module hazard_forward_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5+3*ADDR_W-1:0]   ins,
  input  logic                    ins_valid,
  input  logic                    flush,
  output logic                    stall,
  output logic [SEL_W-1:0]        mux_sel_A,
  output logic [SEL_W-1:0]        mux_sel_B,
  output logic                    imm_sel,
  output logic [IMM_W-1:0]        Imm,
  output logic [4:0]              op_dec,
  output logic [ADDR_W-1:0]       RW_dec,
  output logic                    valid_dec,
  output logic                    mem_en_dec,
  output logic                    mem_rw_dec,
  output logic                    mem_mux_sel_dec
);

  localparam int unsigned OP_W = 5;
  localparam logic [OP_W-1:0] OP_JUMP = 5'b11000;
  localparam logic [OP_W-1:0] OP_LOAD = 5'b10100;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rw;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
  } ins_t;

  ins_t              raw;
  ins_t              dec;
  logic              is_jump;
  logic              is_cjump;
  logic              is_ldst;
  logic              is_imm;
  logic              load_en;

  ins_t              dec_q;
  logic              valid_q;
  logic [IMM_W-1:0]  imm_q;
  logic              imm_sel_q;
  logic              mem_en_q;
  logic              mem_rw_q;

  logic              hist_v  [DEPTH];
  logic [ADDR_W-1:0] hist_rw [DEPTH];

  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;

  // Field decode; jumps carry no register operands, so their fields are zeroed
  always_comb begin
    raw      = ins_t'(ins);
    dec      = raw;
    is_jump  = (raw.op == OP_JUMP);
    is_cjump = (raw.op[4:2] == 3'b111);
    is_ldst  = (raw.op[4:1] == 4'b1010);
    is_imm   = (raw.op[4:3] == 2'b01);
    if (is_jump || is_cjump) begin
      dec.rw = '0;
      dec.ra = '0;
      dec.rb = '0;
    end
  end

  // Load in decode whose result is needed by the instruction waiting in fetch
  always_comb begin
    stall = valid_q && (dec_q.op == OP_LOAD) && ins_valid && !flush &&
            (dec_q.rw != '0) && ((dec_q.rw == dec.ra) || (dec_q.rw == dec.rb));
  end

  assign load_en = ins_valid && !flush && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      dec_q     <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
    end else if (load_en) begin
      valid_q   <= 1'b1;
      dec_q     <= dec;
      imm_q     <= IMM_W'(ins[ADDR_W-1:0]);
      imm_sel_q <= is_imm;
      mem_en_q  <= is_ldst;
      mem_rw_q  <= is_ldst && raw.op[0];
    end else begin
      valid_q   <= 1'b0;
      dec_q     <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
    end
  end

  // Destination history never stalls; bubbles enter as invalid entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        hist_v[k]  <= 1'b0;
        hist_rw[k] <= '0;
      end
    end else begin
      hist_v[0]  <= valid_q;
      hist_rw[0] <= dec_q.rw;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        hist_v[k]  <= hist_v[k-1];
        hist_rw[k] <= hist_rw[k-1];
      end
    end
  end

  // Oldest-to-nearest scan so the nearest matching producer wins
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (hist_v[k] && (hist_rw[k] == dec_q.ra)) sel_a = SEL_W'(k + 1);
      if (hist_v[k] && (hist_rw[k] == dec_q.rb)) sel_b = SEL_W'(k + 1);
    end
    if (!valid_q || (dec_q.ra == '0)) sel_a = '0;
    if (!valid_q || (dec_q.rb == '0)) sel_b = '0;
  end

  assign mux_sel_A       = sel_a;
  assign mux_sel_B       = sel_b;
  assign imm_sel         = imm_sel_q;
  assign Imm             = imm_q;
  assign op_dec          = dec_q.op;
  assign RW_dec          = dec_q.rw;
  assign valid_dec       = valid_q;
  assign mem_en_dec      = mem_en_q;
  assign mem_rw_dec      = mem_rw_q;
  assign mem_mux_sel_dec = mem_en_q && !mem_rw_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (DEPTH 3 and 5) share one stimulus
// stream and are compared each cycle against a queue-based pipeline model.
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset;
  logic [19:0] ins;
  logic        ins_valid;
  logic        flush;

  logic       stall3, imm_sel3, v3, me3, mrw3, mms3;
  logic [1:0] sa3, sb3;
  logic [7:0] imm3;
  logic [4:0] op3, rw3;

  logic       stall5, imm_sel5, v5, me5, mrw5, mms5;
  logic [2:0] sa5, sb5;
  logic [7:0] imm5;
  logic [4:0] op5, rw5;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit #(.ADDR_W(5), .DEPTH(3), .IMM_W(8), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .flush(flush),
    .stall(stall3), .mux_sel_A(sa3), .mux_sel_B(sb3), .imm_sel(imm_sel3), .Imm(imm3),
    .op_dec(op3), .RW_dec(rw3), .valid_dec(v3), .mem_en_dec(me3), .mem_rw_dec(mrw3),
    .mem_mux_sel_dec(mms3)
  );

  hazard_forward_unit #(.ADDR_W(5), .DEPTH(5), .IMM_W(8), .SEL_W(3)) u_dut5 (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .flush(flush),
    .stall(stall5), .mux_sel_A(sa5), .mux_sel_B(sb5), .imm_sel(imm_sel5), .Imm(imm5),
    .op_dec(op5), .RW_dec(rw5), .valid_dec(v5), .mem_en_dec(me5), .mem_rw_dec(mrw5),
    .mem_mux_sel_dec(mms5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_v, m_op, m_rw, m_ra, m_rb, m_imm;
  int hq_v[$];
  int hq_rw[$];

  initial begin
    m_v = 0; m_op = 0; m_rw = 0; m_ra = 0; m_rb = 0; m_imm = 0;
  end

  function automatic bit is_jumpish(input int op);
    return (op == 24) || (op >= 28);
  endfunction

  function automatic int exp_stall();
    int op_i, ra_i, rb_i;
    op_i = int'(ins[19:15]);
    ra_i = is_jumpish(op_i) ? 0 : int'(ins[9:5]);
    rb_i = is_jumpish(op_i) ? 0 : int'(ins[4:0]);
    return (m_v != 0 && m_op == 20 && ins_valid && !flush && m_rw != 0 &&
            (m_rw == ra_i || m_rw == rb_i)) ? 1 : 0;
  endfunction

  // Nearest earlier decode-stage occupant (k cycles ago) that wrote r
  function automatic int exp_sel(input int depth, input int r);
    if (m_v == 0 || r == 0) return 0;
    for (int k = 1; k <= depth; k++)
      if (k <= hq_v.size() && hq_v[k-1] != 0 && hq_rw[k-1] == r) return k;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int st, op_i;
    if (!reset) begin
      m_v = 0; m_op = 0; m_rw = 0; m_ra = 0; m_rb = 0; m_imm = 0;
      hq_v.delete();
      hq_rw.delete();
    end else begin
      st = exp_stall();
      hq_v.push_front(m_v);
      hq_rw.push_front(m_rw);
      if (hq_v.size() > 8) begin
        void'(hq_v.pop_back());
        void'(hq_rw.pop_back());
      end
      if (ins_valid && !flush && st == 0) begin
        op_i  = int'(ins[19:15]);
        m_v   = 1;
        m_op  = op_i;
        m_rw  = is_jumpish(op_i) ? 0 : int'(ins[14:10]);
        m_ra  = is_jumpish(op_i) ? 0 : int'(ins[9:5]);
        m_rb  = is_jumpish(op_i) ? 0 : int'(ins[4:0]);
        m_imm = int'(ins[4:0]);
      end else begin
        m_v = 0; m_op = 0; m_rw = 0; m_ra = 0; m_rb = 0; m_imm = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int ldst, isimm;
    ldst  = (m_v != 0 && (m_op == 20 || m_op == 21)) ? 1 : 0;
    isimm = (m_v != 0 && m_op >= 8 && m_op <= 15) ? 1 : 0;
    chk("stall3", stall3, exp_stall());
    chk("stall5", stall5, exp_stall());
    chk("selA3", sa3, exp_sel(3, m_ra));
    chk("selB3", sb3, exp_sel(3, m_rb));
    chk("selA5", sa5, exp_sel(5, m_ra));
    chk("selB5", sb5, exp_sel(5, m_rb));
    chk("valid3", v3, m_v);
    chk("valid5", v5, m_v);
    chk("op3", op3, m_op);
    chk("op5", op5, m_op);
    chk("rw3", rw3, m_rw);
    chk("rw5", rw5, m_rw);
    chk("imm3", imm3, m_imm);
    chk("imm5", imm5, m_imm);
    chk("imm_sel3", imm_sel3, isimm);
    chk("imm_sel5", imm_sel5, isimm);
    chk("mem_en3", me3, ldst);
    chk("mem_en5", me5, ldst);
    chk("mem_rw3", mrw3, (ldst != 0 && m_op == 21) ? 1 : 0);
    chk("mem_rw5", mrw5, (ldst != 0 && m_op == 21) ? 1 : 0);
    chk("mem_mux3", mms3, (ldst != 0 && m_op == 20) ? 1 : 0);
    chk("mem_mux5", mms5, (ldst != 0 && m_op == 20) ? 1 : 0);
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [19:0] mk(input int op, input int rw, input int ra, input int rb);
    return {5'(op), 5'(rw), 5'(ra), 5'(rb)};
  endfunction

  task automatic drive(input logic [19:0] i, input logic v, input logic f);
    @(posedge clk);
    #1;
    ins       = i;
    ins_valid = v;
    flush     = f;
    #1;
  endtask

  task automatic issue(input int op, input int rw, input int ra, input int rb);
    drive(mk(op, rw, ra, rb), 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(20'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    ins       = '0;
    ins_valid = 1'b0;
    flush     = 1'b0;
    #2 reset  = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", v3, 0);
    chk("rst_op", op3, 0);
    chk("rst_stall", stall3, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle();
      chk("idle_selA", sa3, 0);
      chk("idle_selB", sb3, 0);
    end

    // Forwarding priority: r3, r3, r5 writers then reader(ra=3, rb=5)
    issue(1, 3, 1, 2);
    issue(1, 3, 1, 2);
    issue(1, 5, 1, 2);
    issue(1, 6, 3, 5);
    idle();
    chk("prio_selA3", sa3, 2);
    chk("prio_selB3", sb3, 1);
    chk("prio_selA5", sa5, 2);
    chk("prio_selB5", sb5, 1);
    issue(1, 3, 0, 0);
    issue(1, 7, 3, 5);
    idle();
    chk("near_selA3", sa3, 1);
    chk("near_selB3", sb3, 0);
    chk("near_selB5", sb5, 4);

    // Load-use: LD r4 then consumer of r4, fetch holds the consumer while stalled
    issue(20, 4, 1, 2);
    issue(1, 8, 4, 0);
    chk("lu_stall", stall3, 1);
    chk("lu_mem_en", me3, 1);
    chk("lu_mem_rw", mrw3, 0);
    chk("lu_mem_mux", mms3, 1);
    issue(1, 8, 4, 0);
    chk("lu_stall_off", stall3, 0);
    chk("lu_bubble_v", v3, 0);
    chk("lu_bubble_op", op3, 0);
    idle();
    chk("lu_selA", sa3, 2);
    chk("lu_valid", v3, 1);

    // Zero register, jump masking, immediate, store
    issue(1, 0, 1, 2);
    issue(1, 9, 0, 0);
    idle();
    chk("r0_selA", sa3, 0);
    issue(24, 10, 11, 12);
    issue(1, 14, 10, 10);
    chk("jmp_rw", rw3, 0);
    chk("jmp_valid", v3, 1);
    idle();
    chk("jmp_selA3", sa3, 0);
    chk("jmp_selB5", sb5, 0);
    issue(9, 11, 0, 21);
    issue(21, 0, 4, 4);
    chk("imm_sel", imm_sel3, 1);
    chk("imm_val", imm3, 21);
    idle();
    chk("st_mem_rw", mrw3, 1);
    chk("st_mem_mux", mms3, 0);

    // Flush while a load-use condition holds
    issue(20, 4, 1, 2);
    drive(mk(1, 17, 4, 0), 1'b1, 1'b1);
    chk("fl_stall", stall3, 0);
    issue(1, 18, 17, 17);
    chk("fl_bubble_v", v3, 0);
    issue(1, 19, 17, 17);
    chk("fl_selA1", sa3, 0);
    idle();
    chk("fl_selA2", sa3, 0);
    idle();

    // Deep match only visible with DEPTH=5
    issue(1, 13, 0, 0);
    repeat (4) idle();
    issue(1, 20, 13, 0);
    idle();
    chk("d5_selA5", sa5, 5);
    chk("d5_selA3", sa3, 0);
    issue(1, 13, 0, 0);
    repeat (5) idle();
    issue(1, 20, 13, 0);
    idle();
    chk("d6_selA5", sa5, 0);

    // Asynchronous reset in the middle of a stall
    issue(20, 4, 1, 2);
    issue(1, 8, 4, 0);
    chk("ar_stall_pre", stall3, 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_stall3", stall3, 0);
    chk("ar_stall5", stall5, 0);
    chk("ar_valid", v3, 0);
    chk("ar_op", op3, 0);
    chk("ar_mem_en", me3, 0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ins_valid = 1'b0;
    repeat (3) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
